// File: rtl/demux4_pingpong.sv
// demux4_pingpong: write side of the two-bank pixel buffer feeding the
// 4-lane 2:1 output mux. Groups of four samples are written alternately into
// bank 0 and bank 1. rd_sel steers the mux so the reader always sees a full
// bank while the other bank refills.
// Optional feature: define DEMUX4_STALL_CNT_EN to count cycles in which an
// input group is offered but the buffer cannot accept it.
module demux4_pingpong #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  output logic [WIDTH-1:0] out0_0,
  output logic [WIDTH-1:0] out1_0,
  output logic [WIDTH-1:0] out2_0,
  output logic [WIDTH-1:0] out3_0,
  output logic [WIDTH-1:0] out0_1,
  output logic [WIDTH-1:0] out1_1,
  output logic [WIDTH-1:0] out2_1,
  output logic [WIDTH-1:0] out3_1,
  output logic [1:0]       bank_full,
  output logic             rd_valid,
  output logic             rd_sel,
  input  logic             rd_release,
  output logic [15:0]      stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  logic [WIDTH-1:0] bank0 [4];
  logic [WIDTH-1:0] bank1 [4];
  logic             wr_sel;
  logic             wr_en;
  logic             rel_en;
  occ_t             occ;

  // Handshake: readiness depends only on registered state, never on rd_release
  always_comb begin
    in_ready = ~bank_full[wr_sel];
    rd_valid = bank_full[rd_sel];
    wr_en    = in_valid & in_ready;
    rel_en   = rd_release & rd_valid;
  end

  // Bank contents, full flags, pointers and occupancy; a write and a release
  // in the same cycle always target different banks, so both apply together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
      bank_full <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      occ       <= EMPTY;
    end else begin
      if (wr_en) begin
        if (wr_sel) begin
          bank1[0] <= in_0;
          bank1[1] <= in_1;
          bank1[2] <= in_2;
          bank1[3] <= in_3;
        end else begin
          bank0[0] <= in_0;
          bank0[1] <= in_1;
          bank0[2] <= in_2;
          bank0[3] <= in_3;
        end
        bank_full[wr_sel] <= 1'b1;
        wr_sel            <= ~wr_sel;
      end
      if (rel_en) begin
        bank_full[rd_sel] <= 1'b0;
        rd_sel            <= ~rd_sel;
      end
      case (occ)
        EMPTY:   if (wr_en) occ <= ONE;
        ONE:     if (wr_en && !rel_en) occ <= TWO;
                 else if (rel_en && !wr_en) occ <= EMPTY;
        TWO:     if (rel_en) occ <= ONE;
        default: occ <= EMPTY;
      endcase
    end
  end

  // Occupancy must always agree with the per-bank full flags
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (occ == ((bank_full == 2'b11) ? TWO :
                      (bank_full == 2'b00) ? EMPTY : ONE));
    end
  end

  always_comb begin
    out0_0 = bank0[0];
    out1_0 = bank0[1];
    out2_0 = bank0[2];
    out3_0 = bank0[3];
    out0_1 = bank1[0];
    out1_1 = bank1[1];
    out2_1 = bank1[2];
    out3_1 = bank1[3];
  end

`ifdef DEMUX4_STALL_CNT_EN
  // Saturating count of cycles where upstream offers a group that is refused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
